// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: one LINE_W transfer becomes LINE_W/BURST_W beats.
// Define ADAPTOR_TIMEOUT_EN to add an 8-bit stall watchdog that aborts with pmem_error.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [31:0]        pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic               pmem_error,
  output logic               burst_read,
  output logic               burst_write,
  output logic [31:0]        burst_address,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [31-OFF_W:0]    addr_q;
  logic [LINE_W-1:0]    wline_q;
  logic [LINE_W-1:0]    rbuf_q;
  logic [LINE_W-1:0]    rdata_q;
  logic [LINE_W-1:0]    rline_full;
  logic                 in_burst;
  logic                 accept;
  logic                 last_beat;
  logic                 timeout;
  logic                 unused_addr_bits;

  assign in_burst  = (state == RD) || (state == WR);
  assign accept    = (state == IDLE) && (pmem_read || pmem_write);
  assign last_beat = in_burst && burst_resp && (cnt == LAST_BEAT);

  // The line offset is implied by the burst; the low address bits carry no information.
  assign unused_addr_bits = ^pmem_address[OFF_W-1:0];

`ifdef ADAPTOR_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!in_burst || burst_resp) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 8'd1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end else if (state == DONE) begin
        err_q <= 1'b0;
      end
    end
  end

  // Abort on the stall cycle that would take the watchdog to 255.
  assign timeout    = in_burst && !burst_resp && (wd_q == 8'd254);
  assign pmem_error = err_q;
`else
  assign timeout    = 1'b0;
  assign pmem_error = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pmem_write) begin
          state_nxt = WR;
        end else if (pmem_read) begin
          state_nxt = RD;
        end
      end
      RD, WR: begin
        if (burst_resp) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_BEAT) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end
        end else if (timeout) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Current read beat merged into the partially assembled line.
  always_comb begin
    rline_full = rbuf_q;
    rline_full[cnt*BURST_W +: BURST_W] = burst_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= pmem_address[31:OFF_W];
      end
      if ((state == RD) && last_beat) begin
        rdata_q <= rline_full;
      end
    end
  end

  // NOTE: wide staging registers carry no reset; they are always written before they are read.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && pmem_write) begin
      wline_q <= pmem_wdata;
    end
    if ((state == RD) && burst_resp) begin
      rbuf_q <= rline_full;
    end
  end

  assign pmem_rdata    = rdata_q;
  assign pmem_resp     = (state == DONE);
  assign burst_read    = (state == RD);
  assign burst_write   = (state == WR);
  assign burst_address = in_burst ? {addr_q, {OFF_W{1'b0}}} : 32'd0;
  assign burst_wdata   = (state == WR) ? wline_q[cnt*BURST_W +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a transaction-level model builds the expected
// cycle-by-cycle outputs from each request and its memory wait pattern.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [31:0]  pmem_address = '0;
  logic [255:0] pmem_wdata = '0;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_error;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;

  always #5 clk = ~clk;

  cacheline_adaptor #(.LINE_W(256), .BURST_W(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .pmem_error   (pmem_error),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model outputs for the current cycle, written by the stimulus process.
  logic         exp_valid = 1'b0;
  logic         exp_br = 1'b0;
  logic         exp_bw = 1'b0;
  logic         exp_resp = 1'b0;
  logic         exp_err = 1'b0;
  logic [31:0]  exp_addr = '0;
  logic [63:0]  exp_wdata = '0;
  logic [255:0] exp_rdata = '0;
  logic [255:0] model_rdata = '0;

  logic [63:0]  mem_beat [4];
  int           waits [4];

  int           resp_seen = 0;
  int           resp_before = 0;
  int           last_resp_cyc = -1;
  int           accept_cyc = 0;
  logic [31:0]  last_burst_addr = '0;
  logic [63:0]  wq [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model at every falling edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("burst_read", 256'(burst_read), 256'(exp_br));
      check("burst_write", 256'(burst_write), 256'(exp_bw));
      check("pmem_resp", 256'(pmem_resp), 256'(exp_resp));
      check("pmem_error", 256'(pmem_error), 256'(exp_err));
      check("pmem_rdata", pmem_rdata, exp_rdata);
      if (exp_br || exp_bw) check("burst_address", 256'(burst_address), 256'(exp_addr));
      if (exp_bw) check("burst_wdata", 256'(burst_wdata), 256'(exp_wdata));
    end
    if (pmem_resp) begin
      resp_seen++;
      last_resp_cyc = cyc;
    end
    if (burst_read || burst_write) last_burst_addr = burst_address;
    if (burst_write && burst_resp) wq.push_back(burst_wdata);
  end

  task automatic set_idle_exp();
    exp_br    = 1'b0;
    exp_bw    = 1'b0;
    exp_resp  = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = model_rdata;
    exp_valid = 1'b1;
  endtask

  task automatic scramble_requests();
    pmem_address = $urandom;
    for (int i = 0; i < 8; i++) pmem_wdata[i*32 +: 32] = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      burst_resp  = 1'b0;
      burst_rdata = {$urandom, $urandom};
      set_idle_exp();
    end
  endtask

  // One line transfer; the memory answers beat k after waits[k] stall cycles.
  // With abort_after < 4 reset is pulsed after that many beats instead of completing.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [255:0] wline, input int abort_after);
    logic is_wr;
    is_wr = wr;
    @(posedge clk); #1;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wline;
    burst_resp   = 1'b0;
    set_idle_exp();
    accept_cyc  = cyc;
    resp_before = resp_seen;
    for (int k = 0; k < abort_after; k++) begin
      for (int j = 0; j <= waits[k]; j++) begin
        @(posedge clk); #1;
        scramble_requests();
        burst_resp  = (j == waits[k]);
        burst_rdata = (j == waits[k]) ? mem_beat[k] : {$urandom, $urandom};
        exp_br    = !is_wr;
        exp_bw    = is_wr;
        exp_addr  = {addr[31:5], 5'b0};
        exp_wdata = wline[k*64 +: 64];
        exp_resp  = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = model_rdata;
      end
    end
    @(posedge clk); #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    burst_resp = 1'b0;
    if (abort_after < 4) begin
      rst_n = 1'b0;
      #1;
      check("rst_async_burst_read", 256'(burst_read), 256'(0));
      check("rst_async_pmem_resp", 256'(pmem_resp), 256'(0));
      check("rst_async_pmem_rdata", pmem_rdata, 256'(0));
      check("rst_async_burst_address", 256'(burst_address), 256'(0));
      model_rdata = '0;
      set_idle_exp();
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_idle_exp();
    end else begin
      if (!is_wr) model_rdata = {mem_beat[3], mem_beat[2], mem_beat[1], mem_beat[0]};
      exp_br    = 1'b0;
      exp_bw    = 1'b0;
      exp_resp  = 1'b1;
      exp_err   = 1'b0;
      exp_rdata = model_rdata;
    end
  endtask

  task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3, input int w);
    mem_beat[0] = b0; mem_beat[1] = b1; mem_beat[2] = b2; mem_beat[3] = b3;
    for (int i = 0; i < 4; i++) waits[i] = w;
  endtask

  localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WLINE  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

  initial begin
    logic [255:0] line_b;
    // Reset state
    repeat (2) begin
      @(posedge clk); #1;
      set_idle_exp();
    end
    check("reset_rdata", pmem_rdata, 256'(0));
    check("reset_outputs", 256'({pmem_resp, pmem_error, burst_read, burst_write}), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_idle_exp();
    idle(2);

    // Zero-wait read
    set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0);
    xfer(1'b1, 1'b0, 32'h0000_1234, '0, 4);
    idle(1);
    check("rd0_latency", 256'(last_resp_cyc - accept_cyc), 256'(5));
    check("rd0_pulses", 256'(resp_seen - resp_before), 256'(1));
    check("rd0_burst_address", 256'(last_burst_addr), 256'(32'h0000_1220));
    check("rd0_rdata", pmem_rdata, LINE_A);

    // Write with two stall cycles before every beat
    wq.delete();
    set_beats('0, '0, '0, '0, 2);
    xfer(1'b0, 1'b1, 32'h0000_2040, WLINE, 4);
    idle(1);
    check("wr_latency", 256'(last_resp_cyc - accept_cyc), 256'(13));
    check("wr_pulses", 256'(resp_seen - resp_before), 256'(1));
    check("wr_beat_count", 256'(wq.size()), 256'(4));
    if (wq.size() == 4) begin
      check("wr_beat0", 256'(wq[0]), 256'(64'hAAAA_AAAA_AAAA_AAAA));
      check("wr_beat1", 256'(wq[1]), 256'(64'hBBBB_BBBB_BBBB_BBBB));
      check("wr_beat2", 256'(wq[2]), 256'(64'hCCCC_CCCC_CCCC_CCCC));
      check("wr_beat3", 256'(wq[3]), 256'(64'hDDDD_DDDD_DDDD_DDDD));
    end
    check("wr_rdata_kept", pmem_rdata, LINE_A);

    // Simultaneous read and write: write wins, read is dropped
    set_beats('0, '0, '0, '0, 0);
    waits[1] = 1;
    xfer(1'b1, 1'b1, 32'h0000_3000, ~WLINE, 4);
    idle(4);
    check("simul_rdata_kept", pmem_rdata, LINE_A);

    // Back-to-back write then read
    set_beats('0, '0, '0, '0, 0);
    xfer(1'b0, 1'b1, 32'h0000_4000, WLINE ^ LINE_A, 4);
    set_beats(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5, 0);
    waits[2] = 3;
    xfer(1'b1, 1'b0, 32'h0000_501F, '0, 4);
    idle(1);
    check("b2b_rd_latency", 256'(last_resp_cyc - accept_cyc), 256'(8));
    check("b2b_rd_rdata", pmem_rdata,
          {64'h5A5A_A5A5_5A5A_A5A5, 64'h0F0F_0F0F_F0F0_F0F0,
           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});

    // Reset after three read beats, then a clean read from beat 0
    set_beats(64'h9999_0000_0000_0001, 64'h9999_0000_0000_0002,
              64'h9999_0000_0000_0003, 64'h9999_0000_0000_0004, 0);
    xfer(1'b1, 1'b0, 32'h0000_6000, '0, 3);
    idle(2);
    check("abort_no_resp", 256'(resp_seen - resp_before), 256'(0));
    line_b = {64'h8000_0000_0000_0004, 64'h8000_0000_0000_0003,
              64'h8000_0000_0000_0002, 64'h8000_0000_0000_0001};
    set_beats(line_b[63:0], line_b[127:64], line_b[191:128], line_b[255:192], 1);
    xfer(1'b1, 1'b0, 32'h0000_6000, '0, 4);
    idle(1);
    check("after_abort_rdata", pmem_rdata, line_b);

    // Memory that never answers
    @(posedge clk); #1;
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_7000;
    set_idle_exp();
    accept_cyc  = cyc;
    resp_before = resp_seen;
`ifdef ADAPTOR_TIMEOUT_EN
    repeat (255) begin
      @(posedge clk); #1;
      burst_resp = 1'b0;
      exp_br = 1'b1; exp_bw = 1'b0; exp_resp = 1'b0; exp_err = 1'b0;
      exp_addr = 32'h0000_7000; exp_rdata = model_rdata;
    end
    @(posedge clk); #1;
    pmem_read = 1'b0;
    exp_br = 1'b0; exp_resp = 1'b1; exp_err = 1'b1; exp_rdata = model_rdata;
    idle(2);
    check("timeout_latency", 256'(last_resp_cyc - accept_cyc), 256'(256));
    check("timeout_pulses", 256'(resp_seen - resp_before), 256'(1));
    check("timeout_rdata_kept", pmem_rdata, line_b);
`else
    repeat (1000) begin
      @(posedge clk); #1;
      burst_resp = 1'b0;
      exp_br = 1'b1; exp_bw = 1'b0; exp_resp = 1'b0; exp_err = 1'b0;
      exp_addr = 32'h0000_7000; exp_rdata = model_rdata;
    end
    check("no_timeout_resp", 256'(resp_seen - resp_before), 256'(0));
    check("no_timeout_rdata_kept", pmem_rdata, line_b);
    @(posedge clk); #1;
    pmem_read = 1'b0;
    rst_n = 1'b0;
    model_rdata = '0;
    set_idle_exp();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_idle_exp();
    idle(2);
`endif

    exp_valid = 1'b0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
